// File: rtl/pipelined_cla_addsub_if.sv
// pipelined_cla_addsub_if
//   Operand/result bus for the pipelined add/subtract unit.
//   slave  : the adder side (takes operands, presents results)
//   master : the operand source and result consumer side
//   Signals
//     in_valid/in_ready       operand beat handshake
//     a, b, cin, sub          operands, carry/borrow in, 1 = subtract
//     out_valid/out_ready     result beat handshake
//     s, cout, ovf, zero      result, carry out of MSB, signed overflow, s==0
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub
//   WIDTH-bit add/subtract split into SEG-bit carry-lookahead slices, one
//   slice per pipeline stage, carry registered between stages. Latency is
//   STAGES = WIDTH/SEG cycles, throughput one beat per cycle.
//   Ports
//     clk   rising-edge clock
//     rst   synchronous reset, active high; discards all in-flight beats
//     bus   pipelined_cla_addsub_if.slave (operand and result handshakes)
//   WIDTH must match the interface WIDTH and be a multiple of SEG.

// One lookahead slice: g/p per bit, carry expanded across the slice.
// cm is the carry into the slice MSB, used for signed overflow.
module cla_slice #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           cm
);
  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign s  = p ^ c[SEG-1:0];
  assign co = c[SEG];
  assign cm = c[SEG-1];
endmodule

module pipelined_cla_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_cla_addsub_if.slave bus
);
  localparam int STAGES = WIDTH / SEG;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bx;   // b, inverted in sub mode
    logic             c0;   // slice-0 carry in
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;
  } rsp_t;

  req_t              req;
  rsp_t              rsp_d;
  rsp_t              rsp_q;
  logic              adv;
  logic              take;
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign adv      = ~vld_q[STAGES] | bus.out_ready;
  assign take     = bus.in_valid & adv;
  assign vld_pipe = {vld_q, take};

  // Subtract as a + ~b + ~cin.
  assign req.a  = bus.a;
  assign req.bx = bus.b ^ {WIDTH{bus.sub}};
  assign req.c0 = bus.cin ^ bus.sub;

  always_ff @(posedge clk) begin
    if (rst)      vld_q <= '0;
    else if (adv) vld_q <= vld_pipe[STAGES-1:0];
  end

  // Stage k resolves bits [k*SEG +: SEG]. Each stage register carries only
  // the operand bits still to be resolved (skew) and the sum bits already
  // finished (deskew), so the final stage sees the complete result.
  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stg
    localparam int REM = WIDTH - k*SEG;

    logic [REM-1:0]        src_a;
    logic [REM-1:0]        src_b;
    logic                  src_c;
    logic [SEG-1:0]        sl_s;
    logic                  sl_co;
    logic                  sl_cm;
    logic [(k+1)*SEG-1:0]  done_s;

    if (k == 0) begin : g_src
      assign src_a  = req.a;
      assign src_b  = req.bx;
      assign src_c  = req.c0;
      assign done_s = sl_s;
    end else begin : g_src
      assign src_a  = g_stg[k-1].g_reg.a_q;
      assign src_b  = g_stg[k-1].g_reg.b_q;
      assign src_c  = g_stg[k-1].g_reg.c_q;
      assign done_s = {sl_s, g_stg[k-1].g_reg.s_q};
    end

    cla_slice #(.SEG(SEG)) u_slice (
      .a  (src_a[SEG-1:0]),
      .b  (src_b[SEG-1:0]),
      .ci (src_c),
      .s  (sl_s),
      .co (sl_co),
      .cm (sl_cm)
    );

    if (k < STAGES-1) begin : g_reg
      logic [REM-SEG-1:0]   a_q;
      logic [REM-SEG-1:0]   b_q;
      logic                 c_q;
      logic [(k+1)*SEG-1:0] s_q;

      // Bubbles leave the data registers untouched.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
          s_q <= '0;
        end else if (adv & vld_pipe[k]) begin
          a_q <= src_a[REM-1:SEG];
          b_q <= src_b[REM-1:SEG];
          c_q <= sl_co;
          s_q <= done_s;
        end
      end
    end else begin : g_out
      assign rsp_d.s    = done_s;
      assign rsp_d.cout = sl_co;
      assign rsp_d.ovf  = sl_co ^ sl_cm;
      assign rsp_d.zero = ~|done_s;
    end
  end

  // Result register only loads real beats, so it holds through stalls and
  // keeps the last result across bubbles.
  always_ff @(posedge clk) begin
    if (rst)                             rsp_q <= '0;
    else if (adv & vld_pipe[STAGES-1])   rsp_q <= rsp_d;
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[STAGES];
  assign bus.s         = rsp_q.s;
  assign bus.cout      = rsp_q.cout;
  assign bus.ovf       = rsp_q.ovf;
  assign bus.zero      = rsp_q.zero;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub
//   Directed corner beats, a stalled stream, mid-stream reset and a long
//   random run, all scored against an integer-arithmetic reference model.
module tb_pipelined_cla_addsub;
  localparam int W      = 16;
  localparam int STAGES = 4;

  typedef struct {
    logic [18:0] res;   // {s, cout, ovf, zero}
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk, n_pass;
  int   n_acc, n_out, n_drop;
  bit   rand_rdy, lat_on;
  int   stall_lo, stall_hi;
  logic [18:0] last_res;
  exp_t q[$];

  pipelined_cla_addsub_if #(.WIDTH(W)) bus ();

  pipelined_cla_addsub #(.WIDTH(W), .SEG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed readings.
  function automatic logic [18:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input logic ci, input logic sb);
    int ua, ub, sa, sbv, c, u, sg;
    logic [15:0] r;
    logic co, ov;
    ua = a; ub = b; sa = $signed(a); sbv = $signed(b); c = ci;
    if (!sb) begin u = ua + ub + c;  sg = sa + sbv + c; end
    else     begin u = ua - ub - c;  sg = sa - sbv - c; end
    r  = u[15:0];
    co = sb ? (u >= 0) : (u >= 65536);
    ov = (sg > 32767) || (sg < -32768);
    return {r, co, ov, (r == 16'h0000)};
  endfunction

  // Consumer side: out_ready either random or high outside a stall window.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : !(cyc >= stall_lo && cyc <= stall_hi);
    end
  end

  // Scoreboard, sampled mid-cycle when all handshake signals are settled.
  always @(negedge clk) begin
    if (rst) begin
      n_drop += q.size();
      q.delete();
    end else begin
      chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (bus.out_valid) begin
        if (q.size() == 0) chk("spurious", bus.out_valid, 1'b0);
        else begin
          chk("res", {bus.s, bus.cout, bus.ovf, bus.zero}, q[0].res);
          if (bus.out_ready) begin
            if (lat_on) chk("latency", cyc - q[0].cyc, STAGES);
            last_res = {bus.s, bus.cout, bus.ovf, bus.zero};
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back('{res: ref_op(bus.a, bus.b, bus.cin, bus.sub), cyc: cyc});
        n_acc++;
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
    bit done;
    done = 1'b0;
    bus.a = a; bus.b = b; bus.cin = ci; bus.sub = sb; bus.in_valid = 1'b1;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", done, 1'b1);
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int t = 0; t < 200 && q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain", q.size(), 0);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int base;
    rst = 1'b1; cyc = 0; n_chk = 0; n_pass = 0;
    n_acc = 0; n_out = 0; n_drop = 0;
    rand_rdy = 1'b0; lat_on = 1'b1; stall_lo = -10; stall_hi = -10;
    last_res = '0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_s", bus.s, 16'h0000);
    chk("rst_flags", {bus.cout, bus.ovf, bus.zero}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // Wrap to zero
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0); drain();
    chk("wrap_zero", last_res, {16'h0000, 1'b1, 1'b0, 1'b1});
    // Signed overflow, add and subtract
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0); drain();
    chk("ovf_add", last_res, {16'h8000, 1'b0, 1'b1, 1'b0});
    send(16'h8000, 16'h0001, 1'b0, 1'b1); drain();
    chk("ovf_sub", last_res, {16'h7FFF, 1'b1, 1'b1, 1'b0});
    // Borrow, with and without borrow-in
    send(16'h0003, 16'h0005, 1'b0, 1'b1); drain();
    chk("borrow", last_res, {16'hFFFE, 1'b0, 1'b0, 1'b0});
    send(16'h0003, 16'h0005, 1'b1, 1'b1); drain();
    chk("borrow_in", last_res, {16'hFFFD, 1'b0, 1'b0, 1'b0});

    // Back-to-back stream with the consumer stalling on cycles 6-8
    lat_on = 1'b0;
    base = n_out;
    stall_lo = cyc + 5; stall_hi = cyc + 7;
    for (int i = 0; i < 8; i++) send(16'(i), 16'(i * 16'h1111), 1'b0, 1'b0);
    drain();
    chk("stream_count", n_out - base, 8);
    chk("stream_last", last_res[18:3], 16'h777E);

    // Reset with three beats in flight
    lat_on = 1'b1;
    for (int i = 0; i < 3; i++) send(16'(i + 5), 16'h0100, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_out_valid", bus.out_valid, 1'b0);
    chk("rst2_s", bus.s, 16'h0000);
    chk("rst2_flags", {bus.cout, bus.ovf, bus.zero}, 3'b000);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    send(16'h0001, 16'h0002, 1'b0, 1'b0); drain();
    chk("after_rst", last_res, {16'h0003, 1'b0, 1'b0, 1'b0});

    // Random beats, random gaps and random back-pressure
    lat_on = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom);
        @(posedge clk); #1;
      end
      send(pick(), pick(), 1'($urandom), 1'($urandom));
    end
    bus.in_valid = 1'b0;
    rand_rdy = 1'b0;
    drain();

    chk("beat_count", n_out, n_acc - n_drop);
    chk("dropped", n_drop, 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule
